// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder computing a + b + cin, one bit per clock.
// A single full-add cell and a carry flop walk the operands LSB first; the sum
// is assembled MSB-down in a shift register. Valid/ready on both sides.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow port ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_count;
    logic             r_carry;
    logic             r_cout;
    logic             r_start_ready;
    logic             r_done_valid;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_ra_next;
    logic [WIDTH-1:0] w_rb_next;
    logic [WIDTH-1:0] w_sum_next;

    // Full-add cell on the current LSBs plus next-state shift values.
    // Shifts are written as >> plus a bit insert so WIDTH=1 needs no special slice.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        w_s        = r_ra[0] ^ r_rb[0] ^ r_carry;
        w_c        = (r_ra[0] & r_rb[0]) | (r_ra[0] & r_carry) | (r_rb[0] & r_carry);
        w_ra_next  = r_ra >> 1;
        w_rb_next  = r_rb >> 1;
        w_sum_next = r_sum >> 1;
        w_sum_next[WIDTH-1] = w_s;
    end

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state       <= IDLE;
            r_ra          <= '0;
            r_rb          <= '0;
            r_sum         <= '0;
            r_count       <= '0;
            r_carry       <= 1'b0;
            r_cout        <= 1'b0;
            r_start_ready <= 1'b1;
            r_done_valid  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf         <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_ra          <= a;
                        r_rb          <= b;
                        r_carry       <= cin;
                        r_count       <= '0;
                        r_start_ready <= 1'b0;
                        r_state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_ra    <= w_ra_next;
                    r_rb    <= w_rb_next;
                    r_carry <= w_c;
                    r_sum   <= w_sum_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST) begin
                        r_cout       <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_carry is the carry into the MSB on this final edge.
                        r_ovf        <= r_carry ^ w_c;
`endif
                        r_done_valid <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        r_done_valid  <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_done_valid  <= 1'b0;
                    r_start_ready <= 1'b1;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = r_start_ready;
    assign done_valid  = r_done_valid;
    assign sum         = r_sum;
    assign cout        = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf         = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder at WIDTH=8.
// Expected sums/carries/overflows are hand-computed constants in the steps below.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       done_valid;
    logic       done_ready;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .sum         (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout        (cout),
        .ovf         (ovf)
`else
        .cout        (cout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands, count edges (including the accept edge) until done_valid,
    // then check the result. done_ready is left as the caller set it.
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ic, input logic [7:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        check({tag, "_start_ready"}, start_ready, 1);
        a = ia; b = ib; cin = ic; start_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                start_valid = 1'b0;
                check({tag, "_busy"}, start_ready, 0);
            end
        end while (!done_valid && n < 20);
        check({tag, "_latency"}, n, 9);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, ovf, eo);
`else
        if (eo !== 1'bx) checks = checks + 0;
`endif
    endtask

    task automatic finish_op(input string tag, input logic [7:0] es);
        @(posedge clk); #1;
        check({tag, "_idle_dv"}, done_valid, 0);
        check({tag, "_idle_rdy"}, start_ready, 1);
        check({tag, "_held_sum"}, sum, es);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; done_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state held while idle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_start_ready", start_ready, 1);
            check("rst_done_valid", done_valid, 0);
            check("rst_sum", sum, 8'h00);
            check("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
            check("rst_ovf", ovf, 0);
`endif
        end

        run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        finish_op("zero", 8'h00);
        run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        finish_op("ff_01", 8'h00);
        run_op("0f_f0_c", 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0);
        finish_op("0f_f0_c", 8'h00);
        run_op("3c_5a", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1);
        finish_op("3c_5a", 8'h96);
        run_op("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        finish_op("7f_01", 8'h80);
        run_op("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        finish_op("80_80", 8'h00);

        // Backpressure: result frozen, held start ignored until back in IDLE.
        done_ready = 1'b0;
        run_op("bp", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        a = 8'hA5; b = 8'h5A; cin = 1'b1; start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_dv", done_valid, 1);
            check("bp_sum", sum, 8'h46);
            check("bp_rdy", start_ready, 0);
        end
        @(negedge clk) done_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_dv", done_valid, 0);
        check("bp_release_rdy", start_ready, 1);
        @(posedge clk); #1;
        check("bp_held_accept", start_ready, 0);
        start_valid = 1'b0;
        seen = 1;
        while (!done_valid && seen < 20) begin
            @(posedge clk); #1;
            seen++;
        end
        check("bp2_latency", seen, 9);
        check("bp2_sum", sum, 8'h00);
        check("bp2_cout", cout, 1);
        finish_op("bp2", 8'h00);

        // Reset on the 3rd SHIFT edge discards the operation.
        @(negedge clk);
        a = 8'h77; b = 8'h11; cin = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1 start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_rdy", start_ready, 1);
        check("mid_rst_dv", done_valid, 0);
        check("mid_rst_sum", sum, 8'h00);
        check("mid_rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("mid_rst_ovf", ovf, 0);
`endif
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_valid) seen++;
        end
        check("mid_rst_no_done", seen, 0);
        run_op("post_rst", 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0);
        finish_op("post_rst", 8'h2C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
